// File: rtl/ssim_pair_buffer.sv
// Captures one image pair into on-chip memory, computes the fixed-point mean of x
// with a 32-step restoring divider, then replays x/y alongside the held mean.
module ssim_pair_buffer #(
    parameter int NUM_INPUTS = 784,
    parameter int PIX_W      = 8,
    parameter int FRAC_BITS  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [PIX_W-1:0] in_x,
    input  logic [PIX_W-1:0] in_y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_x,
    output logic [31:0]      out_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [31:0]      mean_x,
    output logic             mean_valid,
    output logic             busy
);
    localparam int CNT_W = $clog2(NUM_INPUTS);
    localparam int SUM_W = PIX_W + CNT_W;
    localparam int DVS_W = $clog2(NUM_INPUTS + 1);
    localparam int REM_W = DVS_W + 1;
    localparam int DIV_W = 32 + DVS_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
    localparam logic [REM_W-1:0] DIVISOR  = REM_W'(NUM_INPUTS);

    typedef enum logic [1:0] {LOAD, DIVIDE, REPLAY} state_t;

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [SUM_W-1:0] sum;
    logic [5:0]       div_cnt;
    logic [DVS_W-1:0] rem;
    logic [31:0]      quo;

    logic [PIX_W-1:0] mem_x [NUM_INPUTS];
    logic [PIX_W-1:0] mem_y [NUM_INPUTS];

    logic             accept;
    logic             advance;
    logic [SUM_W-1:0] sum_acc;
    logic [DIV_W-1:0] dividend;
    logic [REM_W-1:0] trial;

    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid || out_ready;
    assign sum_acc  = sum + SUM_W'(in_x);
    // Bits of the shifted sum above DIV_W are always zero (quotient fits 32 bits).
    assign dividend = DIV_W'({sum_acc, {FRAC_BITS{1'b0}}});
    assign trial    = {rem, quo[31]};

    always_ff @(posedge clk) begin
        if (!clr && accept) begin
            mem_x[wr_cnt] <= in_x;
            mem_y[wr_cnt] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            sum        <= '0;
            div_cnt    <= '0;
            rem        <= '0;
            quo        <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            mean_x     <= '0;
            mean_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (wr_cnt == LAST_IDX) begin
                            // Dividend splits into the initial remainder and the quotient shifter.
                            wr_cnt   <= '0;
                            sum      <= '0;
                            quo      <= dividend[31:0];
                            rem      <= dividend[32 +: DVS_W];
                            div_cnt  <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= DIVIDE;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_W'(1);
                            sum    <= sum_acc;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_cnt == 6'd32) begin
                        mean_x     <= quo;
                        mean_valid <= 1'b1;
                        rd_cnt     <= '0;
                        state      <= REPLAY;
                    end else begin
                        div_cnt <= div_cnt + 6'd1;
                        if (trial >= DIVISOR) begin
                            rem <= DVS_W'(trial - DIVISOR);
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= trial[DVS_W-1:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end
                end
                REPLAY: begin
                    if (advance) begin
                        if (out_valid && out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            mean_valid <= 1'b0;
                            in_ready   <= 1'b1;
                            busy       <= 1'b0;
                            state      <= LOAD;
                        end else begin
                            // Memory read register doubles as the output register.
                            out_x     <= 32'(mem_x[rd_cnt]);
                            out_y     <= 32'(mem_y[rd_cnt]);
                            out_valid <= 1'b1;
                            out_last  <= (rd_cnt == LAST_IDX);
                            rd_cnt    <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ssim_pair_buffer.sv
// Randomized self-checking bench for ssim_pair_buffer; three instances cover
// NUM_INPUTS=4, NUM_INPUTS=3 and the default 784-pair configuration.
module tb_ssim_pair_buffer;
    localparam int FRAC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       clr;
    logic [2:0]       in_valid;
    logic [2:0]       out_ready;
    logic [2:0][7:0]  in_x;
    logic [2:0][7:0]  in_y;
    wire  [2:0]       in_ready;
    wire  [2:0]       out_valid;
    wire  [2:0]       out_last;
    wire  [2:0]       mean_valid;
    wire  [2:0]       busy;
    wire  [2:0][31:0] out_x;
    wire  [2:0][31:0] out_y;
    wire  [2:0][31:0] mean_x;

    logic [7:0]       img_x [784];
    logic [7:0]       img_y [784];
    logic [2:0][31:0] exp_mean;

    int checks   = 0;
    int failures = 0;

    ssim_pair_buffer #(.NUM_INPUTS(4), .PIX_W(8), .FRAC_BITS(16)) u_dut4 (
        .clk(clk), .clr(clr[0]), .in_x(in_x[0]), .in_y(in_y[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_x(out_x[0]), .out_y(out_y[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0]), .mean_x(mean_x[0]),
        .mean_valid(mean_valid[0]), .busy(busy[0])
    );

    ssim_pair_buffer #(.NUM_INPUTS(3), .PIX_W(8), .FRAC_BITS(16)) u_dut3 (
        .clk(clk), .clr(clr[1]), .in_x(in_x[1]), .in_y(in_y[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_x(out_x[1]), .out_y(out_y[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1]), .mean_x(mean_x[1]),
        .mean_valid(mean_valid[1]), .busy(busy[1])
    );

    ssim_pair_buffer u_dut_def (
        .clk(clk), .clr(clr[2]), .in_x(in_x[2]), .in_y(in_y[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_x(out_x[2]), .out_y(out_y[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_last(out_last[2]), .mean_x(mean_x[2]),
        .mean_valid(mean_valid[2]), .busy(busy[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 x=255, 2 x=0, 3 x=i+1 / y=10*(i+1)
    task automatic gen_image(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       begin img_x[i] = 8'd255;        img_y[i] = 8'($urandom); end
                2:       begin img_x[i] = 8'd0;          img_y[i] = 8'($urandom); end
                3:       begin img_x[i] = 8'(i + 1);     img_y[i] = 8'(10 * (i + 1)); end
                default: begin img_x[i] = 8'($urandom);  img_y[i] = 8'($urandom); end
            endcase
        end
    endtask

    task automatic load_image(input int d, input int n, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                in_x[d]     = 8'($urandom);
                step();
            end
            in_valid[d] = 1'b1;
            in_x[d]     = img_x[i];
            in_y[d]     = img_y[i];
            checks++;
            if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL load_ready dut%0d pair %0d: in_ready=%b busy=%b, need 1 0",
                         d, i, in_ready[d], busy[d]);
            end
            step();
        end
        in_valid[d] = 1'b0;
        if (cnt == n) begin
            checks++;
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
                failures++;
                $display("FAIL load_done dut%0d: in_ready=%b busy=%b, need 0 1",
                         d, in_ready[d], busy[d]);
            end
        end
    endtask

    task automatic wait_mean(input int d, input int n);
        longint s = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++) s += longint'(img_x[i]);
        exp_mean[d] = 32'((s << FRAC) / n);
        while (mean_valid[d] !== 1'b1 && cyc < 100) begin
            checks++;
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                failures++;
                $display("FAIL divide_state dut%0d cyc %0d: in_ready=%b busy=%b out_valid=%b, need 0 1 0",
                         d, cyc, in_ready[d], busy[d], out_valid[d]);
            end
            step();
            cyc++;
        end
        checks++;
        if (cyc != 33) begin
            failures++;
            $display("FAIL mean_latency dut%0d: got %0d cycles, need 33", d, cyc);
        end
        checks++;
        if (mean_x[d] !== exp_mean[d]) begin
            failures++;
            $display("FAIL mean_value dut%0d: got %08h, need %08h", d, mean_x[d], exp_mean[d]);
        end
    endtask

    // mode 0 out_ready=1, 1 pattern 1,0,0,1, 2 random; stops after stop_at transfers
    task automatic run_replay(input int d, input int n, input int mode, input int stop_at);
        int k = 0;
        int cyc = 0;
        logic rdy;
        logic [3:0] pat = 4'b1001;
        while (k < stop_at && cyc < 8 * n + 40) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready[d] = rdy;
            checks++;
            if (out_valid[d] !== (cyc != 0) || in_ready[d] !== 1'b0 || busy[d] !== 1'b1 ||
                mean_valid[d] !== 1'b1 || mean_x[d] !== exp_mean[d]) begin
                failures++;
                $display("FAIL replay_ctrl dut%0d cyc %0d: ov=%b ready=%b busy=%b mv=%b mx=%08h, need %b 0 1 1 %08h",
                         d, cyc, out_valid[d], in_ready[d], busy[d], mean_valid[d], mean_x[d],
                         (cyc != 0), exp_mean[d]);
            end
            if (out_valid[d] === 1'b1) begin
                checks++;
                if (out_x[d] !== 32'(img_x[k]) || out_y[d] !== 32'(img_y[k]) ||
                    out_last[d] !== (k == n - 1)) begin
                    failures++;
                    $display("FAIL replay_beat dut%0d beat %0d: x=%0d y=%0d last=%b, need %0d %0d %b",
                             d, k, out_x[d], out_y[d], out_last[d], img_x[k], img_y[k], (k == n - 1));
                end
                if (rdy) k++;
            end
            step();
            cyc++;
        end
        out_ready[d] = 1'b0;
        checks++;
        if (k != stop_at) begin
            failures++;
            $display("FAIL replay_timeout dut%0d: %0d beats transferred, need %0d", d, k, stop_at);
        end
        if (stop_at == n) begin
            checks++;
            if (out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 || mean_valid[d] !== 1'b0 ||
                in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL replay_end dut%0d: ov=%b last=%b mv=%b ready=%b busy=%b, need 0 0 0 1 0",
                         d, out_valid[d], out_last[d], mean_valid[d], in_ready[d], busy[d]);
            end
        end
    endtask

    task automatic test_reset();
        clr = '1; in_valid = '0; out_ready = '0; in_x = '0; in_y = '0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({in_ready[d], busy[d], out_valid[d], out_last[d], mean_valid[d]} !== 5'b10000 ||
                out_x[d] !== 32'd0 || out_y[d] !== 32'd0 || mean_x[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d: ready=%b busy=%b ov=%b last=%b mv=%b ox=%0h oy=%0h mx=%0h, need 1 0 0 0 0 0 0 0",
                         d, in_ready[d], busy[d], out_valid[d], out_last[d], mean_valid[d],
                         out_x[d], out_y[d], mean_x[d]);
            end
        end
        clr = '0;
    endtask

    task automatic test_basic();
        gen_image(4, 3);
        load_image(0, 4, 4);
        wait_mean(0, 4);
        checks++;
        if (mean_x[0] !== 32'h00028000) begin
            failures++;
            $display("FAIL basic_mean: got %08h, need 00028000", mean_x[0]);
        end
        run_replay(0, 4, 0, 4);
    endtask

    task automatic test_three();
        img_x[0] = 8'd1; img_x[1] = 8'd1; img_x[2] = 8'd2;
        img_y[0] = 8'd7; img_y[1] = 8'd8; img_y[2] = 8'd9;
        load_image(1, 3, 3);
        wait_mean(1, 3);
        checks++;
        if (mean_x[1] !== 32'h00015555) begin
            failures++;
            $display("FAIL three_mean: got %08h, need 00015555", mean_x[1]);
        end
        run_replay(1, 3, 0, 3);
    endtask

    task automatic test_stall();
        gen_image(4, 0);
        load_image(0, 4, 4);
        wait_mean(0, 4);
        run_replay(0, 4, 1, 4);
    endtask

    task automatic test_clear();
        // partial load, then clear with a valid pair present
        gen_image(4, 1);
        load_image(0, 4, 2);
        clr[0] = 1'b1; in_valid[0] = 1'b1; in_x[0] = img_x[2];
        step();
        checks++;
        if ({in_ready[0], busy[0], out_valid[0], out_last[0], mean_valid[0]} !== 5'b10000 ||
            out_x[0] !== 32'd0 || out_y[0] !== 32'd0 || mean_x[0] !== 32'd0) begin
            failures++;
            $display("FAIL clear_load: ready=%b busy=%b ov=%b last=%b mv=%b mx=%0h, need 1 0 0 0 0 0",
                     in_ready[0], busy[0], out_valid[0], out_last[0], mean_valid[0], mean_x[0]);
        end
        clr[0] = 1'b0; in_valid[0] = 1'b0;
        gen_image(4, 0);
        load_image(0, 4, 4);
        wait_mean(0, 4);
        run_replay(0, 4, 0, 2);
        // clear mid-replay with a transfer offered
        clr[0] = 1'b1; out_ready[0] = 1'b1;
        step();
        checks++;
        if ({in_ready[0], busy[0], out_valid[0], out_last[0], mean_valid[0]} !== 5'b10000 ||
            out_x[0] !== 32'd0 || out_y[0] !== 32'd0 || mean_x[0] !== 32'd0) begin
            failures++;
            $display("FAIL clear_replay: ready=%b busy=%b ov=%b last=%b mv=%b ox=%0h oy=%0h mx=%0h, need 1 0 0 0 0 0 0 0",
                     in_ready[0], busy[0], out_valid[0], out_last[0], mean_valid[0],
                     out_x[0], out_y[0], mean_x[0]);
        end
        clr[0] = 1'b0; out_ready[0] = 1'b0;
        gen_image(4, 3);
        load_image(0, 4, 4);
        wait_mean(0, 4);
        run_replay(0, 4, 2, 4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] hx;
        logic [7:0] hy;
        hx = 8'($urandom);
        hy = 8'($urandom);
        gen_image(4, 0);
        load_image(0, 4, 4);
        in_valid[0] = 1'b1; in_x[0] = hx; in_y[0] = hy;
        wait_mean(0, 4);
        run_replay(0, 4, 0, 4);
        gen_image(4, 0);
        img_x[0] = hx;
        img_y[0] = hy;
        load_image(0, 4, 4);
        wait_mean(0, 4);
        run_replay(0, 4, 2, 4);
    endtask

    task automatic test_default();
        gen_image(784, 1);
        load_image(2, 784, 784);
        wait_mean(2, 784);
        checks++;
        if (mean_x[2] !== 32'h00FF0000) begin
            failures++;
            $display("FAIL default_max_mean: got %08h, need 00FF0000", mean_x[2]);
        end
        run_replay(2, 784, 0, 784);
        gen_image(784, 2);
        load_image(2, 784, 784);
        wait_mean(2, 784);
        checks++;
        if (mean_x[2] !== 32'h00000000) begin
            failures++;
            $display("FAIL default_zero_mean: got %08h, need 00000000", mean_x[2]);
        end
        run_replay(2, 784, 0, 784);
        gen_image(784, 0);
        load_image(2, 784, 784);
        wait_mean(2, 784);
        run_replay(2, 784, 2, 784);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            gen_image(4, 0);
            load_image(0, 4, 4);
            wait_mean(0, 4);
            run_replay(0, 4, 2, 4);
        end
        for (int r = 0; r < 8; r++) begin
            gen_image(3, 0);
            load_image(1, 3, 3);
            wait_mean(1, 3);
            run_replay(1, 3, 2, 3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_three();
        test_stall();
        test_clear();
        test_back_to_back();
        test_default();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
